// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg
//   Shared definitions for the multiplier-sharing arbiter: FSM state
//   encodings and a constant-evaluable ceil(log2) helper used to size the
//   grant index and the WAIT timer.
package mul_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // ceil(log2(v)); returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
//   Combinational round-robin winner selection. Returns the first requester
//   with req_valid set, scanning upward from rr_ptr and wrapping modulo N_REQ.
// Ports
//   req_valid    in   N_REQ  pending requests
//   rr_ptr       in   IW     index with highest priority this cycle
//   grant_valid  out  1      at least one request pending
//   grant_idx    out  IW     index of the winner (0 when grant_valid=0)
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IW-1:0]    rr_ptr,
    output logic             grant_valid,
    output logic [IW-1:0]    grant_idx
);

    int idx;

    // Walk offsets from the far end back towards rr_ptr so that the last
    // match written is the one closest to rr_ptr in round-robin order.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one multi-cycle multiplier among N_REQ requesters with round-robin
//   arbitration and a single operation in flight. Operands are registered and
//   held for the whole operation; the product (or a timeout error) returns to
//   the granted requester over a valid/ready response channel.
//
//   Handshakes: a request transfers in a cycle where req_valid[i] and
//   req_ready[i] are both 1; req_ready is a combinational one-hot offered only
//   in IDLE. A response transfers in a cycle where rsp_valid[i] and
//   rsp_ready[i] are both 1; rsp_valid is raised only in RESP, for grant_id,
//   and stays up with rsp_data/rsp_err held until that transfer.
//
// Ports
//   clk, rst                 clock, async active-low reset
//   req_valid/req_ready      request handshake, one bit per requester
//   req_a/req_b              operands, requester i at [i*DW +: DW]
//   rsp_valid/rsp_ready      response handshake, one bit per requester
//   rsp_data/rsp_err         product (0 on timeout) and timeout flag
//   mul_a/mul_b/mul_start    registered operands and start pulse
//   mul_valid/mul_result     multiplier completion
//   busy, grant_id           status: not IDLE, current/last grant
//   dbg_state                current FSM state encoding
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int DW      = 32,
    parameter  int TIMEOUT = 64,
    localparam int IW      = clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [N_REQ-1:0]    rsp_valid,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_err,
    output logic [DW-1:0]       mul_a,
    output logic [DW-1:0]       mul_b,
    output logic                mul_start,
    input  logic                mul_valid,
    input  logic [DW-1:0]       mul_result,
    output logic                busy,
    output logic [IW-1:0]       grant_id,
    output logic [1:0]          dbg_state
);

    localparam int TW = clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [DW-1:0] mul_a_q, mul_a_d;
    logic [DW-1:0] mul_b_q, mul_b_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          timed_out;

    rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign timed_out = (timer_q == TW'(TIMEOUT - 1));

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        timer_d    = timer_q;
        case (state_q)
            IDLE: begin
                // req_ready only ever points at a valid requester, so a
                // winner means the transfer happens this cycle.
                if (grant_valid) begin
                    state_d    = ISSUE;
                    mul_a_d    = req_a[int'(grant_idx)*DW +: DW];
                    mul_b_d    = req_b[int'(grant_idx)*DW +: DW];
                    grant_id_d = grant_idx;
                    rr_ptr_d   = (grant_idx == IW'(N_REQ - 1)) ? '0
                                                               : grant_idx + IW'(1);
                end
            end
            ISSUE: begin
                // Any mul_valid here belongs to nothing we issued; ignore it.
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_valid) begin
                    rsp_data_d = mul_result;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (timed_out) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else if (timer_q != TW'(TIMEOUT)) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready[grant_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. req_ready is gated by rst so it reads 0 while reset is held
    // even though it is combinational from req_valid.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid && rst) begin
                    req_ready[grant_idx] = 1'b1;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                busy      = 1'b1;
            end
            WAIT: begin
                busy = 1'b1;
            end
            RESP: begin
                busy                  = 1'b1;
                rsp_valid[grant_id_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign grant_id  = grant_id_q;
    assign dbg_state = state_q;

endmodule
